// File: rtl/mixer_sequencer.sv
// Frame sequencer for a 4-input pipelined audio mixer: gathers one sample per
// channel on each tick, drives the mixer, waits out its latency and captures the sum.
module mixer_sequencer #(
  parameter int SAMPLE_W = 8,
  parameter int MIX_W    = 10,
  parameter int LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [3:0]            mute,
  input  logic [3:0]            ch_valid,
  input  logic [4*SAMPLE_W-1:0] ch_data,
  output logic [3:0]            ch_ready,
  output logic [SAMPLE_W-1:0]   audio0,
  output logic [SAMPLE_W-1:0]   audio1,
  output logic [SAMPLE_W-1:0]   audio2,
  output logic [SAMPLE_W-1:0]   audio3,
  input  logic [MIX_W-1:0]      mix_in,
  output logic [MIX_W-1:0]      mix_out,
  output logic                  mix_valid,
  output logic                  busy,
  output logic [3:0]            underrun,
  output logic                  overrun,
  input  logic                  clear_flags
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_LOAD,
    S_WAIT,
    S_CAPTURE
  } state_t;

  localparam logic [3:0] LAT_L = 4'(LATENCY);

  state_t                r_state;
  logic [4*SAMPLE_W-1:0] r_latch;
  logic [4*SAMPLE_W-1:0] r_audio;
  logic [3:0]            r_cnt;
  logic [MIX_W-1:0]      r_mix_out;
  logic                  r_mix_valid;
  logic [3:0]            r_underrun;
  logic                  r_overrun;

  logic [4*SAMPLE_W-1:0] w_gather_data;
  logic [3:0]            w_under_set;
  logic                  w_gather;
  logic                  w_over_set;

  assign w_gather   = (r_state == S_GATHER);
  assign w_over_set = sample_tick & (r_state != S_IDLE);

  // Muted or empty channels contribute zero; muted channels never count as underrun.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      assign w_gather_data[gi*SAMPLE_W +: SAMPLE_W] =
        (ch_valid[gi] & ~mute[gi]) ? ch_data[gi*SAMPLE_W +: SAMPLE_W] : '0;
      assign w_under_set[gi] = w_gather & ~ch_valid[gi] & ~mute[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_latch     <= '0;
      r_audio     <= '0;
      r_cnt       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
    end else begin
      r_mix_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sample_tick) r_state <= S_GATHER;
        end
        S_GATHER: begin
          r_latch <= w_gather_data;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_audio <= r_latch;
          r_cnt   <= LAT_L;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The WAIT state spans LATENCY cycles of stable mixer inputs.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_mix_out   <= mix_in;
          r_mix_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flag event in the same cycle as clear_flags takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underrun <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_underrun <= (clear_flags ? 4'b0 : r_underrun) | w_under_set;
      r_overrun  <= (clear_flags ? 1'b0 : r_overrun) | w_over_set;
    end
  end

  assign ch_ready  = w_gather ? ch_valid : 4'b0;
  assign audio0    = r_audio[0*SAMPLE_W +: SAMPLE_W];
  assign audio1    = r_audio[1*SAMPLE_W +: SAMPLE_W];
  assign audio2    = r_audio[2*SAMPLE_W +: SAMPLE_W];
  assign audio3    = r_audio[3*SAMPLE_W +: SAMPLE_W];
  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;
  assign busy      = (r_state != S_IDLE);
  assign underrun  = r_underrun;
  assign overrun   = r_overrun;

endmodule
